// File: rtl/nor_page_prog_seq_pkg.sv
// Shared constants for the NOR page-program sequencer.
// NOR_CYCLE_PROGRAM normally arrives from cmd_defs.v; the guarded default keeps this slice self-contained.
`ifndef NOR_CYCLE_PROGRAM
`define NOR_CYCLE_PROGRAM 6'h03
`endif

package nor_page_prog_seq_pkg;
    localparam int NOR_CMD_BITS = 6;
    localparam int WB_ADR_BITS  = 32;
endpackage

// File: rtl/nor_page_prog_seq_fifo.sv
// pp_word_fifo: synchronous word FIFO with registered head-of-queue read data.
module pp_word_fifo #(
    parameter int DEPTH    = 16,
    parameter int DATABITS = 16
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                push,
    input  logic [DATABITS-1:0] push_data,
    input  logic                pop,
    input  logic                flush,
    output logic                full,
    output logic                empty,
    output logic [DATABITS-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [DATABITS-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]         cnt;
    logic                do_push, do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_nxt  = rd_ptr + 1'b1;

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_nxt;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (!do_push && do_pop) cnt <= cnt - 1'b1;
            // head register follows the write when the queue is (or becomes) empty
            if (do_push && (empty || (do_pop && cnt == ONE_CNT))) rd_data <= push_data;
            else if (do_pop)                                     rd_data <= mem[rd_nxt];
        end
    end
endmodule

// File: rtl/nor_page_prog_seq.sv
// Page-program data-phase sequencer: one Wishbone NOR_CYCLE_PROGRAM write per buffered word.
// Build option PPSEQ_PAGE_WRAP_EN: address increment wraps inside the aligned PAGE_WORDS page.
module nor_page_prog_seq
    import nor_page_prog_seq_pkg::*;
#(
    parameter int ADDRBITS   = 26,
    parameter int DATABITS   = 16,
    parameter int DEPTH      = 16,
    parameter int COUNTBITS  = 16,
    parameter int PAGE_WORDS = 256
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 start_i,
    input  logic [ADDRBITS-1:0]  start_addr_i,
    input  logic                 word_valid_i,
    input  logic [DATABITS-1:0]  word_data_i,
    output logic                 word_ready_o,
    input  logic                 end_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [COUNTBITS-1:0] prog_count_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [31:0]          wb_adr_o,
    output logic [DATABITS-1:0]  wb_dat_o,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    input  logic                 wb_stall_i
);
    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_ISSUE, S_WAIT_ACK, S_DRAIN, S_DONE
    } state_t;

    localparam int PAGE_BITS = $clog2(PAGE_WORDS);
`ifdef PPSEQ_PAGE_WRAP_EN
    localparam bit PAGE_WRAP = 1'b1;
`else
    localparam bit PAGE_WRAP = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [ADDRBITS-1:0]   addr_q, addr_nxt;
    logic [COUNTBITS-1:0]  count_q;
    logic                  err_q, end_q;
    logic                  latch_start, addr_inc, err_set;
    logic                  fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [DATABITS-1:0]   fifo_rd;
    logic                  in_burst;

    pp_word_fifo #(.DEPTH(DEPTH), .DATABITS(DATABITS)) u_fifo (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .push      (fifo_push),
        .push_data (word_data_i),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .rd_data   (fifo_rd)
    );

    assign in_burst  = (state_q == S_RUN) || (state_q == S_ISSUE) || (state_q == S_WAIT_ACK);
    assign fifo_push = word_valid_i && in_burst && !fifo_full && !abort_i;
    assign addr_nxt  = PAGE_WRAP ? {addr_q[ADDRBITS-1:PAGE_BITS], addr_q[PAGE_BITS-1:0] + 1'b1}
                                 : addr_q + 1'b1;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // abort outranks err, and err outranks ack
    always_comb begin
        state_d     = state_q;
        latch_start = 1'b0;
        addr_inc    = 1'b0;
        err_set     = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                latch_start = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (abort_i) begin
                    fifo_flush = 1'b1;
                    state_d    = S_IDLE;
                end else if (!fifo_empty) state_d = S_ISSUE;
                else if (end_q)           state_d = S_DONE;
            end
            S_ISSUE: begin
                if (abort_i) begin
                    fifo_flush = 1'b1;
                    state_d    = S_IDLE;
                end else if (!wb_stall_i) state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (abort_i) begin
                    fifo_flush = 1'b1;
                    state_d    = S_IDLE;
                end else if (wb_err_i) begin
                    err_set    = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = S_DRAIN;
                end else if (wb_ack_i) begin
                    fifo_pop = 1'b1;
                    addr_inc = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_DRAIN: begin
                if (abort_i)    state_d = S_IDLE;
                else if (end_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            end_q   <= 1'b0;
        end else if (latch_start) begin
            addr_q  <= start_addr_i;
            count_q <= '0;
            err_q   <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            if (addr_inc) addr_q <= addr_nxt;
            if (addr_inc && count_q != '1) count_q <= count_q + 1'b1;
            if (err_set) err_q <= 1'b1;
            if (end_i && (in_burst || state_q == S_DRAIN)) end_q <= 1'b1;
        end
    end

    assign word_ready_o = (in_burst && !fifo_full) || (state_q == S_DRAIN);
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign err_o        = err_q;
    assign prog_count_o = count_q;
    assign wb_cyc_o     = (state_q == S_ISSUE) || (state_q == S_WAIT_ACK);
    assign wb_stb_o     = (state_q == S_ISSUE);
    assign wb_we_o      = wb_cyc_o;
    // address/data bus held at zero outside a cycle so idle outputs read as 0
    assign wb_adr_o     = wb_cyc_o ? WB_ADR_BITS'({NOR_CMD_BITS'(`NOR_CYCLE_PROGRAM), addr_q}) : '0;
    assign wb_dat_o     = wb_cyc_o ? fifo_rd : '0;
endmodule

// File: tb/tb_nor_page_prog_seq.sv
// Directed bench for nor_page_prog_seq with a small Wishbone slave responder.
`ifndef NOR_CYCLE_PROGRAM
`define NOR_CYCLE_PROGRAM 6'h03
`endif

module tb_nor_page_prog_seq;
    localparam logic [5:0] PROG = `NOR_CYCLE_PROGRAM;

    logic        clk_i = 0, reset_ni = 0;
    logic        start_i = 0, word_valid_i = 0, end_i = 0, abort_i = 0;
    logic [25:0] start_addr_i = '0;
    logic [15:0] word_data_i = '0;
    logic        wb_ack_i = 0, wb_err_i = 0, wb_stall_i = 0;
    logic        word_ready_o, busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o;
    logic [15:0] prog_count_o, wb_dat_o;
    logic [31:0] wb_adr_o;

    always #5 clk_i = ~clk_i;

    nor_page_prog_seq dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .start_addr_i(start_addr_i),
        .word_valid_i(word_valid_i), .word_data_i(word_data_i), .word_ready_o(word_ready_o),
        .end_i(end_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .prog_count_o(prog_count_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_stall_i(wb_stall_i)
    );

    int          tests = 0, fails = 0;
    logic [47:0] iss_q[$];
    int          issued = 0, stb_cycles = 0, stab_err = 0, done_cnt = 0, stall_left = 0, err_at = 0;
    bit          auto_ack = 1;
    logic        prev_hold = 0;
    logic [31:0] prev_adr = '0;
    logic [15:0] prev_dat = '0;

    // record accepted strobes and check bus stability while stalled
    always @(posedge clk_i) begin
        if (wb_stb_o) begin
            stb_cycles++;
            if (prev_hold && (wb_adr_o !== prev_adr || wb_dat_o !== prev_dat)) stab_err++;
            prev_hold = wb_stall_i;
            prev_adr  = wb_adr_o;
            prev_dat  = wb_dat_o;
            if (!wb_stall_i) begin
                iss_q.push_back({wb_adr_o, wb_dat_o});
                issued++;
            end
        end else prev_hold = 0;
    end

    always @(negedge clk_i) begin
        wb_ack_i = 0; wb_err_i = 0; wb_stall_i = 0;
        if (wb_stb_o && stall_left > 0) begin
            wb_stall_i = 1;
            stall_left--;
        end
        if (wb_cyc_o && !wb_stb_o) begin
            if (err_at != 0 && issued == err_at) wb_err_i = 1;
            else if (auto_ack)                   wb_ack_i = 1;
        end
        if (done_o) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_burst(input logic [25:0] a);
        iss_q.delete();
        issued = 0;
        start_addr_i = a;
        start_i = 1;
        @(negedge clk_i);
        start_i = 0;
    endtask

    task automatic push(input logic [15:0] d, input bit last);
        int n;
        n = 0;
        word_valid_i = 1; word_data_i = d; end_i = last;
        while (!word_ready_o && n < 300) begin @(negedge clk_i); n++; end
        @(negedge clk_i);
        word_valid_i = 0; end_i = 0;
        if (n >= 300) chk("push_timeout", 64'(n), 0);
    endtask

    task automatic end_pulse();
        end_i = 1;
        @(negedge clk_i);
        end_i = 0;
    endtask

    task automatic wait_done(input string tag);
        int n, d0;
        n = 0; d0 = done_cnt;
        while (done_cnt == d0 && n < 500) begin @(negedge clk_i); n++; end
        chk(tag, n < 500, 1);
        @(negedge clk_i);
    endtask

    task automatic chk_iss(input string tag, input int i, input logic [25:0] a, input logic [15:0] d);
        logic [47:0] e;
        e = {PROG, a, d};
        chk(tag, (i < iss_q.size()) ? iss_q[i] : 48'hDEAD_DEAD_DEAD, e);
    endtask

    initial begin
        logic [15:0] t1d [4];
        logic [25:0] t5a [3];
        logic [25:0] a0;
        int n;
        t1d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        #3;
        chk("reset_ctl", {busy_o, done_o, err_o, word_ready_o, wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        chk("reset_bus", {wb_adr_o, wb_dat_o, prog_count_o}, 0);
        @(negedge clk_i); @(negedge clk_i);
        reset_ni = 1;
        @(negedge clk_i);

        // basic four-word burst plus first-word latency
        start_burst(26'h100);
        chk("t1_busy", busy_o, 1);
        push(t1d[0], 0);
        chk("t1_lat_edgeN", wb_cyc_o, 0);
        @(negedge clk_i);
        chk("t1_lat_edgeN1", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b111);
        for (int i = 1; i < 4; i++) push(t1d[i], 0);
        end_pulse();
        wait_done("t1_done");
        chk("t1_n", iss_q.size(), 4);
        for (int i = 0; i < 4; i++) chk_iss("t1_wr", i, 26'h100 + 26'(i), t1d[i]);
        chk("t1_count", prog_count_o, 4);
        chk("t1_err", err_o, 0);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_idle", busy_o, 0);

        // stall three cycles on the first strobe
        stall_left = 3; stb_cycles = 0; stab_err = 0;
        start_burst(26'h200);
        push(16'hAAAA, 0);
        end_pulse();
        wait_done("t2_done");
        chk("t2_stable", stab_err, 0);
        chk("t2_stb_cycles", stb_cycles, 4);
        chk("t2_n", iss_q.size(), 1);
        chk_iss("t2_wr", 0, 26'h200, 16'hAAAA);

        // backpressure: ack withheld until FIFO fills
        auto_ack = 0;
        start_burst(26'h300);
        for (int i = 0; i < 16; i++) push(16'h1000 + 16'(i), 0);
        chk("t3_full_ready", word_ready_o, 0);
        chk("t3_one_issued", iss_q.size(), 1);
        auto_ack = 1;
        for (int i = 16; i < 20; i++) push(16'h1000 + 16'(i), 0);
        end_pulse();
        wait_done("t3_done");
        chk("t3_n", iss_q.size(), 20);
        for (int i = 0; i < 20; i++) chk_iss("t3_wr", i, 26'h300 + 26'(i), 16'h1000 + 16'(i));
        chk("t3_count", prog_count_o, 20);

        // bus error on the second word
        err_at = 2;
        start_burst(26'h400);
        for (int i = 0; i < 5; i++) push(16'h5000 + 16'(i), 0);
        end_pulse();
        wait_done("t4_done");
        err_at = 0;
        chk("t4_err", err_o, 1);
        chk("t4_count", prog_count_o, 1);
        chk("t4_n", iss_q.size(), 2);
        chk("t4_done_cnt", done_cnt, 4);

        // address rollover, end_i on the last word
`ifdef PPSEQ_PAGE_WRAP_EN
        a0 = 26'h00000FE;
        t5a = '{26'h00000FE, 26'h00000FF, 26'h0000000};
`else
        a0 = 26'h3FFFFFE;
        t5a = '{26'h3FFFFFE, 26'h3FFFFFF, 26'h0000000};
`endif
        start_burst(a0);
        chk("t5_err_clr", err_o, 0);
        for (int i = 0; i < 3; i++) push(16'h7000 + 16'(i), i == 2);
        wait_done("t5_done");
        chk("t5_n", iss_q.size(), 3);
        for (int i = 0; i < 3; i++) chk_iss("t5_wr", i, t5a[i], 16'h7000 + 16'(i));

        // abort while waiting for ack
        auto_ack = 0;
        start_burst(26'h500);
        push(16'h6666, 0);
        n = 0;
        while (!(wb_cyc_o && !wb_stb_o) && n < 50) begin @(negedge clk_i); n++; end
        chk("t6_reach_wait", n < 50, 1);
        a0 = 26'(done_cnt);
        abort_i = 1;
        @(posedge clk_i); #1;
        chk("t6_cyc_low", wb_cyc_o, 0);
        chk("t6_idle", busy_o, 0);
        @(negedge clk_i);
        abort_i = 0;
        chk("t6_count", prog_count_o, 0);
        chk("t6_ready", word_ready_o, 0);
        repeat (3) @(negedge clk_i);
        chk("t6_no_done", 64'(done_cnt), 64'(a0));
        auto_ack = 1;
        start_burst(26'h600);
        end_pulse();
        wait_done("t6_empty_done");
        chk("t6_fifo_flushed", iss_q.size(), 0);

        // asynchronous reset in the middle of ISSUE
        stall_left = 20;
        start_burst(26'h700);
        push(16'h7777, 0);
        n = 0;
        while (!wb_stb_o && n < 50) begin @(negedge clk_i); n++; end
        chk("t7_reach_issue", n < 50, 1);
        #2 reset_ni = 0;
        #1;
        chk("t7_rst_ctl", {busy_o, done_o, err_o, word_ready_o, wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        chk("t7_rst_bus", {wb_adr_o, wb_dat_o, prog_count_o}, 0);
        stall_left = 0;
        @(negedge clk_i);
        reset_ni = 1;
        @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
